// File: rtl/avmm_cmd_master_if.sv
// Command/response handshake and Avalon-MM master signals of avmm_cmd_master.
// The master modport is the block itself; the slave modport is its environment.
interface avmm_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [20:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [31:0] cmd_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic [20:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_burstcount;
  logic        avm_debugaccess;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, rsp_ready,
           avm_waitrequest, avm_readdata, avm_readdatavalid,
    output cmd_ready, rsp_valid, rsp_data, rsp_status, avm_address, avm_read,
           avm_write, avm_writedata, avm_byteenable, avm_burstcount, avm_debugaccess
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, rsp_ready,
           avm_waitrequest, avm_readdata, avm_readdatavalid,
    input  cmd_ready, rsp_valid, rsp_data, rsp_status, avm_address, avm_read,
           avm_write, avm_writedata, avm_byteenable, avm_burstcount, avm_debugaccess
  );
endinterface

// File: rtl/avmm_cmd_master.sv
// Command-driven Avalon-MM master: write, read, read-modify-write and poll-until-match,
// with per-phase timeout and exactly one response per accepted command.
module avmm_cmd_master #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int POLL_MAX       = 255,
  parameter int POLL_GAP       = 16
) (
  input  logic              clk_100_clk,
  input  logic              reset_100_reset_n,
  avmm_cmd_master_if.master bus
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;
  localparam logic [2:0] S_RSP     = 3'd5;

  localparam logic [1:0] OP_WR   = 2'd0;
  localparam logic [1:0] OP_RD   = 2'd1;
  localparam logic [1:0] OP_RMW  = 2'd2;
  localparam logic [1:0] OP_POLL = 2'd3;

  localparam logic [1:0] ST_OK  = 2'd0;
  localparam logic [1:0] ST_TO  = 2'd1;
  localparam logic [1:0] ST_EXH = 2'd2;

  // One bit wider than the counters so the +1 compare cannot wrap.
  localparam logic [16:0] TO_LIM   = 17'(TIMEOUT_CYCLES);
  localparam logic [8:0]  POLL_LIM = 9'(POLL_MAX);
  localparam logic [8:0]  GAP_LIM  = 9'(POLL_GAP);

  function automatic logic [31:0] rmw_merge(input logic [31:0] rd, input logic [31:0] nb,
                                            input logic [31:0] mask);
    return (rd & ~mask) | (nb & mask);
  endfunction

  function automatic logic poll_match(input logic [31:0] rd, input logic [31:0] exp_v,
                                      input logic [31:0] mask);
    return (rd & mask) == (exp_v & mask);
  endfunction

  logic [2:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] data_q, data_d;
  logic [31:0] mask_q, mask_d;
  logic [31:0] rd_q, rd_d;
  logic [15:0] phase_q, phase_d;
  logic [7:0]  poll_q, poll_d;
  logic [7:0]  gap_q, gap_d;
  logic [20:0] avm_address_q, avm_address_d;
  logic        avm_read_q, avm_read_d;
  logic        avm_write_q, avm_write_d;
  logic [31:0] avm_writedata_q, avm_writedata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [1:0]  rsp_status_q, rsp_status_d;
  logic        phase_done_s;
  logic        abort_s;

  assign phase_done_s = ({1'b0, phase_q} + 17'd1) >= TO_LIM;

  // Next-state and next-output computation for the command sequencer.
  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    data_d          = data_q;
    mask_d          = mask_q;
    rd_d            = rd_q;
    phase_d         = phase_q;
    poll_d          = poll_q;
    gap_d           = gap_q;
    avm_address_d   = avm_address_q;
    avm_read_d      = avm_read_q;
    avm_write_d     = avm_write_q;
    avm_writedata_d = avm_writedata_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_data_d      = rsp_data_q;
    rsp_status_d    = rsp_status_q;
    abort_s         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d          = bus.cmd_op;
          avm_address_d = bus.cmd_addr;
          data_d        = bus.cmd_data;
          mask_d        = bus.cmd_mask;
          rd_d          = 32'd0;
          poll_d        = 8'd0;
          phase_d       = 16'd0;
          if (bus.cmd_op == OP_WR) begin
            avm_write_d     = 1'b1;
            avm_writedata_d = bus.cmd_data;
            state_d         = S_WR_REQ;
          end else begin
            avm_read_d = 1'b1;
            state_d    = S_RD_REQ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_REQ: begin
        if (!bus.avm_waitrequest) begin
          avm_read_d = 1'b0;
          phase_d    = 16'd0;
          state_d    = S_RD_WAIT;
        end else if (phase_done_s) begin
          abort_s = 1'b1;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end
      S_RD_WAIT: begin
        if (bus.avm_readdatavalid) begin
          rd_d = bus.avm_readdata;
          case (op_q)
            OP_RMW: begin
              avm_writedata_d = rmw_merge(bus.avm_readdata, data_q, mask_q);
              avm_write_d     = 1'b1;
              phase_d         = 16'd0;
              state_d         = S_WR_REQ;
            end
            OP_POLL: begin
              if (poll_match(bus.avm_readdata, data_q, mask_q)) begin
                rsp_data_d   = bus.avm_readdata;
                rsp_status_d = ST_OK;
                state_d      = S_RSP;
              end else if (({1'b0, poll_q} + 9'd1) >= POLL_LIM) begin
                rsp_data_d   = bus.avm_readdata;
                rsp_status_d = ST_EXH;
                state_d      = S_RSP;
              end else begin
                poll_d  = poll_q + 8'd1;
                gap_d   = 8'd0;
                state_d = S_GAP;
              end
            end
            default: begin
              rsp_data_d   = bus.avm_readdata;
              rsp_status_d = ST_OK;
              state_d      = S_RSP;
            end
          endcase
        end else if (phase_done_s) begin
          abort_s = 1'b1;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end
      S_WR_REQ: begin
        if (!bus.avm_waitrequest) begin
          avm_write_d  = 1'b0;
          rsp_data_d   = (op_q == OP_RMW) ? rd_q : 32'd0;
          rsp_status_d = ST_OK;
          state_d      = S_RSP;
        end else if (phase_done_s) begin
          abort_s = 1'b1;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end
      S_GAP: begin
        if (({1'b0, gap_q} + 9'd1) >= GAP_LIM) begin
          avm_read_d = 1'b1;
          phase_d    = 16'd0;
          state_d    = S_RD_REQ;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      S_RSP: begin
        // rsp_valid rises the cycle after data/status settle, then holds until consumed.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort_s) begin
      avm_read_d   = 1'b0;
      avm_write_d  = 1'b0;
      rsp_status_d = ST_TO;
      rsp_data_d   = (state_q == S_WR_REQ && op_q == OP_RMW) ? rd_q : 32'd0;
      state_d      = S_RSP;
    end else begin
      rsp_status_d = rsp_status_d;
    end
  end

  // State, counters and all bus/response outputs are registered here.
  always_ff @(posedge clk_100_clk or negedge reset_100_reset_n) begin
    if (!reset_100_reset_n) begin
      state_q         <= S_IDLE;
      op_q            <= 2'd0;
      data_q          <= 32'd0;
      mask_q          <= 32'd0;
      rd_q            <= 32'd0;
      phase_q         <= 16'd0;
      poll_q          <= 8'd0;
      gap_q           <= 8'd0;
      avm_address_q   <= 21'd0;
      avm_read_q      <= 1'b0;
      avm_write_q     <= 1'b0;
      avm_writedata_q <= 32'd0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= 32'd0;
      rsp_status_q    <= 2'd0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      data_q          <= data_d;
      mask_q          <= mask_d;
      rd_q            <= rd_d;
      phase_q         <= phase_d;
      poll_q          <= poll_d;
      gap_q           <= gap_d;
      avm_address_q   <= avm_address_d;
      avm_read_q      <= avm_read_d;
      avm_write_q     <= avm_write_d;
      avm_writedata_q <= avm_writedata_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      rsp_status_q    <= rsp_status_d;
    end
  end

  assign bus.cmd_ready       = (state_q == S_IDLE);
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_data        = rsp_data_q;
  assign bus.rsp_status      = rsp_status_q;
  assign bus.avm_address     = avm_address_q;
  assign bus.avm_read        = avm_read_q;
  assign bus.avm_write       = avm_write_q;
  assign bus.avm_writedata   = avm_writedata_q;
  assign bus.avm_byteenable  = 4'hF;
  assign bus.avm_burstcount  = 1'b1;
  assign bus.avm_debugaccess = 1'b0;
endmodule
